// File: rtl/onehot_event_counter.sv
// onehot_event_counter
//   Per-channel event counters fed by the one-hot output of a 3:8 decoder.
//   A well-formed vector (exactly one bit set) accepted in RUN increments
//   that channel's counter. An all-zero vector, or one with more than one bit
//   set, is logged in a sticky flag and a saturating error counter instead.
//   A clr pulse starts an 8-cycle sweep (CLEAR) that zeroes one counter per
//   cycle. Input is refused while the sweep runs. Counts are read back
//   through a registered read port with one cycle of latency.
//
//   Optional feature, selected by the macro ONEHOT_CNT_SAT_EN:
//     defined   - channel counters saturate at all-ones and hold there
//     undefined - channel counters wrap from all-ones back to zero
//   The error counter saturates in both builds.
module onehot_event_counter #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_onehot,
  output logic             in_ready,
  input  logic             clr,
  output logic             busy,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             err_onehot,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt [8];

  logic             take_clr;
  logic             xfer;
  logic             is_onehot;
  logic [2:0]       ch;

  // Decode the incoming vector: is it a legal strobe, and which channel does it name?
  always_comb begin
    // NOTE: every combinational output is given a default first, so that no
    // path through the block leaves a value unassigned and infers a latch.
    ch        = '0;
    is_onehot = (in_onehot != 8'h00) && ((in_onehot & (in_onehot - 8'd1)) == 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (in_onehot[i]) ch = 3'(i);
    end
    take_clr = (state == RUN) && clr;
    // A clear in the same cycle as a transfer consumes the vector without
    // counting it or logging an error.
    xfer     = (state == RUN) && in_valid && in_ready && !clr;
  end

  // Next-state logic: RUN enters CLEAR on clr. CLEAR leaves after channel 7 is swept.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (clr) next_state = CLEAR;
      CLEAR:   if (idx == 3'd7) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // State register. in_ready and busy are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of block ordering.
    if (rst) begin
      state    <= RUN;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == RUN);
      busy     <= (next_state == CLEAR);
    end
  end

  // Sweep index: restarts at 0 when a clear is taken and advances once per CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (take_clr) begin
      idx <= '0;
    end else if (state == CLEAR) begin
      idx <= idx + 3'd1;
    end
  end

  // Channel counters: zeroed by the sweep in CLEAR, incremented by a legal strobe in RUN.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the counter array is only eight small registers, so it is built
    // from resettable flops rather than RAM. That lets reset zero it at once.
    if (rst) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else if (state == CLEAR) begin
      cnt[idx] <= '0;
    end else if (xfer && is_onehot) begin
`ifdef ONEHOT_CNT_SAT_EN
      if (cnt[ch] != {CNT_W{1'b1}}) cnt[ch] <= cnt[ch] + CNT_W'(1);
`else
      cnt[ch] <= cnt[ch] + CNT_W'(1);
`endif
    end
  end

  // Error state: cleared when a clear is taken, updated by every accepted malformed vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_onehot <= 1'b0;
      err_cnt    <= '0;
    end else if (take_clr) begin
      err_onehot <= 1'b0;
      err_cnt    <= '0;
    end else if (xfer && !is_onehot) begin
      err_onehot <= 1'b1;
      if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  // Read port: captures the stored count before any update on this edge. The data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= cnt[rd_addr];
    end
  end

endmodule
